// File: rtl/text_pixel_serializer_if.sv
// Signal bundle between the sync generator, text RAM, font ROM, cursor
// control and the text pixel serializer. The serializer uses the slave side.
interface text_pixel_serializer_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [9:0]        x;
    logic [9:0]        y;
    logic              display_area_in;
    logic              frame_start;
    logic [ADDR_W-1:0] text_addr;
    logic [7:0]        text_data;
    logic [10:0]       font_addr;
    logic [7:0]        font_data;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              cursor_en;
    logic              serial_output;
    logic              display_area;

    modport master (
        output x, y, display_area_in, frame_start,
        output text_data, font_data,
        output cursor_col, cursor_row, cursor_en,
        input  text_addr, font_addr, serial_output, display_area
    );

    modport slave (
        input  x, y, display_area_in, frame_start,
        input  text_data, font_data,
        input  cursor_col, cursor_row, cursor_en,
        output text_addr, font_addr, serial_output, display_area
    );
endinterface

// File: rtl/text_pixel_serializer.sv
// Text-mode pixel generator: turns (x, y, display_area_in) into a serial
// pixel stream through a text RAM lookup and a font ROM lookup. Five-cycle
// fixed latency, one pixel per clock. Supports inverse video (char bit 7)
// and a blinking underline cursor.
module text_pixel_serializer #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    text_pixel_serializer_if.slave bus
);
    localparam int unsigned GX_W    = $clog2(CHAR_W);
    localparam int unsigned GY_W    = $clog2(CHAR_H);
    localparam int unsigned COL_W   = 10 - GX_W;
    localparam int unsigned ROW_W   = 10 - GY_W;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Per-pixel context carried alongside the memory lookups.
    typedef struct packed {
        logic             de;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [GY_W-1:0]  glyph_row;
        logic [GX_W-1:0]  glyph_col;
    } cell_t;

    cell_t              s0_c;
    cell_t              s1;
    cell_t              s2;
    cell_t              s3;
    cell_t              s4;
    logic               inv3;
    logic               inv4;
    logic [ADDR_W-1:0]  addr_c;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               cursor_hit_c;
    logic               pix_c;

    // Cell decode and linear text address; blanked pixels read address 0.
    always_comb begin
        s0_c.de        = bus.display_area_in;
        s0_c.col       = bus.x[9:GX_W];
        s0_c.row       = bus.y[9:GY_W];
        s0_c.glyph_row = bus.y[GY_W-1:0];
        s0_c.glyph_col = bus.x[GX_W-1:0];
        addr_c         = '0;
        if (bus.display_area_in) begin
            addr_c = ADDR_W'(32'(s0_c.row) * COLS + 32'(s0_c.col));
        end
    end

    // Underline cursor on the bottom two glyph rows; off-screen cursors never match.
    always_comb begin
        cursor_hit_c = bus.cursor_en && blink_phase
                    && (32'(bus.cursor_col) < COLS)
                    && (32'(bus.cursor_row) < ROWS)
                    && (s4.col == COL_W'(bus.cursor_col))
                    && (s4.row == ROW_W'(bus.cursor_row))
                    && (32'(s4.glyph_row) >= CHAR_H - 2);
        pix_c        = (bus.font_data[~s4.glyph_col] ^ inv4) | cursor_hit_c;
    end

    // Lookup pipeline: text addr -> text data -> font addr -> font data -> pixel.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            bus.text_addr     <= '0;
            bus.font_addr     <= '0;
            bus.serial_output <= 1'b0;
            bus.display_area  <= 1'b0;
            s1                <= '0;
            s2                <= '0;
            s3                <= '0;
            s4                <= '0;
            inv3              <= 1'b0;
            inv4              <= 1'b0;
        end else begin
            bus.text_addr     <= addr_c;
            s1                <= s0_c;
            s2                <= s1;
            bus.font_addr     <= 11'({bus.text_data[6:0], s2.glyph_row});
            inv3              <= bus.text_data[7];
            s3                <= s2;
            s4                <= s3;
            inv4              <= inv3;
            bus.serial_output <= pix_c & s4.de;
            bus.display_area  <= s4.de;
        end
    end

    // Frame counter driving the cursor blink; phase starts visible after reset.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (bus.frame_start) begin
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_text_pixel_serializer.sv
// Bench for text_pixel_serializer: RAM/ROM models, a frame-level behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_text_pixel_serializer;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    text_pixel_serializer_if bus_if ();

    text_pixel_serializer dut (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    logic [7:0] rom [0:2047];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Synchronous memories: data valid the cycle after the address.
    always @(posedge clk) begin
        bus_if.text_data <= ram[bus_if.text_addr];
        bus_if.font_data <= rom[bus_if.font_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        de;
        logic [11:0] ta;
        logic [10:0] fa;
        logic        ser;
    } exp_t;

    // What the outputs must be for one input pixel, straight from the text-mode rules.
    function automatic exp_t predict(input int x, input int y, input bit de, input int nfs,
                                     input bit en, input int cc, input int cr);
        exp_t       e;
        int         col, row, gr, gc, addr;
        logic [7:0] ch, fr;
        bit         pix;
        col  = x / 8;
        row  = y / 16;
        gr   = y % 16;
        gc   = x % 8;
        addr = de ? row * 80 + col : 0;
        ch   = ram[addr];
        e.fa = {ch[6:0], 4'(gr)};
        fr   = rom[e.fa];
        pix  = fr[7 - gc] ^ ch[7];
        if (en && ((nfs / 30) % 2 == 0) && cc < 80 && cr < 30 &&
            col == cc && row == cr && gr >= 14)
            pix = 1'b1;
        e.de  = de;
        e.ta  = 12'(addr);
        e.ser = pix & de;
        return e;
    endfunction

    exp_t        hist [0:5];
    int unsigned fill = 0;
    int unsigned nfs  = 0;

    // Every cycle: record the inputs about to be sampled and check delayed outputs.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_text_addr", 32'(bus_if.text_addr), 0);
            chk("rst_font_addr", 32'(bus_if.font_addr), 0);
            chk("rst_serial", 32'(bus_if.serial_output), 0);
            chk("rst_display_area", 32'(bus_if.display_area), 0);
            fill = 0;
            nfs  = 0;
        end else begin
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = predict(int'(bus_if.x), int'(bus_if.y), bus_if.display_area_in, int'(nfs),
                              bus_if.cursor_en, int'(bus_if.cursor_col), int'(bus_if.cursor_row));
            if (fill < 6) fill++;
            if (fill > 1) chk("text_addr", 32'(bus_if.text_addr), 32'(hist[1].ta));
            if (fill > 3) chk("font_addr", 32'(bus_if.font_addr), 32'(hist[3].fa));
            if (fill > 5) begin
                chk("serial", 32'(bus_if.serial_output), 32'(hist[5].ser));
                chk("display_area", 32'(bus_if.display_area), 32'(hist[5].de));
            end else begin
                chk("flush_serial", 32'(bus_if.serial_output), 0);
                chk("flush_display_area", 32'(bus_if.display_area), 0);
            end
            if (bus_if.frame_start) nfs++;
        end
    end

    task automatic step(input int x, input int y, input bit de, input bit fs);
        bus_if.x               = 10'(x);
        bus_if.y               = 10'(y);
        bus_if.display_area_in = de;
        bus_if.frame_start     = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    // Eight pixels of one glyph row starting at x0 on line 0, checked literally.
    task automatic glyph_row_test(input int x0, input logic [7:0] pat, input string name);
        for (int i = 0; i < 12; i++) begin
            step(i < 8 ? x0 + i : 0, 0, i < 8, 1'b0);
            if (i + 1 == 3) chk({name, "_font_addr"}, 32'(bus_if.font_addr), 32'h410);
            if (i + 1 >= 5) begin
                chk({name, "_pixel"}, 32'(bus_if.serial_output), 32'(pat[7 - (i - 4)]));
                chk({name, "_display_area"}, 32'(bus_if.display_area), 1);
            end
        end
        idle(5);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 255));
        ram[0]     = 8'h41;
        ram[1]     = 8'hC1;
        ram[2399]  = 8'h7F;
        ram[163]   = 8'h00;
        rom[11'h410] = 8'h18;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        bus_if.x               = '0;
        bus_if.y               = '0;
        bus_if.display_area_in = 1'b0;
        bus_if.frame_start     = 1'b0;
        bus_if.cursor_en       = 1'b0;
        bus_if.cursor_col      = '0;
        bus_if.cursor_row      = '0;

        #1 reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(6);

        // Plain glyph row, then the same row in inverse video.
        glyph_row_test(0, 8'b0001_1000, "glyph");
        glyph_row_test(8, 8'b1110_0111, "inverse");

        // Bottom-right cell.
        step(639, 479, 1'b1, 1'b0);
        chk("last_cell_text_addr", 32'(bus_if.text_addr), 2399);
        idle(2);
        chk("last_cell_font_addr", 32'(bus_if.font_addr), 32'h7FF);
        idle(5);

        // Blanking masks both address and pixel even over lit font data.
        step(96, 0, 1'b0, 1'b0);
        chk("blank_text_addr", 32'(bus_if.text_addr), 0);
        idle(4);
        chk("blank_serial", 32'(bus_if.serial_output), 0);
        chk("blank_display_area", 32'(bus_if.display_area), 0);
        idle(5);

        // Cursor blink over frames counted from reset.
        bus_if.cursor_en  = 1'b1;
        bus_if.cursor_col = 7'd3;
        bus_if.cursor_row = 5'd2;
        for (int f = 0; f <= 90; f++) begin
            step(24, 46, 1'b1, 1'b0);
            step(31, 47, 1'b1, 1'b0);
            step(24, 45, 1'b1, 1'b0);
            step(28, 44, 1'b1, 1'b0);
            step(0, 0, 1'b0, 1'b0);
            if (f == 0 || f == 29 || f == 30 || f == 59 || f == 60 || f == 90)
                chk("cursor_blink", 32'(bus_if.serial_output),
                    32'((f < 30 || (f >= 60 && f < 90)) ? 1 : 0));
            idle(5);
            step(0, 0, 1'b0, 1'b1);
            idle(5);
        end

        // Asynchronous reset in the middle of an active line.
        for (int i = 0; i < 6; i++) step(24 + i, 46, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_text_addr", 32'(bus_if.text_addr), 0);
        chk("async_rst_font_addr", 32'(bus_if.font_addr), 0);
        chk("async_rst_serial", 32'(bus_if.serial_output), 0);
        chk("async_rst_display_area", 32'(bus_if.display_area), 0);
        step(24, 46, 1'b1, 1'b1);
        step(25, 46, 1'b1, 1'b1);
        reset = 1'b1;
        step(24, 46, 1'b1, 1'b0);
        idle(4);
        chk("cursor_after_reset", 32'(bus_if.serial_output), 1);
        idle(5);

        // Randomised bursts with random cursor placement and blink phase.
        for (int b = 0; b < 30; b++) begin
            int x, y, cc, cr, nframes;
            bit de;
            bus_if.cursor_en  = 1'($urandom_range(0, 1));
            bus_if.cursor_col = 7'(($urandom_range(0, 4) == 0) ? $urandom_range(80, 127)
                                                               : $urandom_range(0, 79));
            bus_if.cursor_row = 5'(($urandom_range(0, 4) == 0) ? $urandom_range(30, 31)
                                                               : $urandom_range(0, 29));
            nframes = int'($urandom_range(0, 40));
            for (int k = 0; k < nframes; k++) step(0, 0, 1'b0, 1'b1);
            idle(5);
            cc = int'(bus_if.cursor_col);
            cr = int'(bus_if.cursor_row);
            for (int p = 0; p < 40; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    x = cc * 8 + int'($urandom_range(0, 7));
                    y = cr * 16 + int'($urandom_range(12, 15));
                end else begin
                    x = int'($urandom_range(0, 799));
                    y = int'($urandom_range(0, 524));
                end
                de = (x < 640) && (y < 480) && ($urandom_range(0, 7) != 0);
                step(x, y, de, 1'b0);
            end
            idle(5);
        end

        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/text_pixel_serializer.md
Name: text_pixel_serializer

Overview:
- Text-mode pixel generator that sits directly upstream of the RGB output stage.
- Takes pixel coordinates and the display-area flag from the VGA sync generator, fetches the character code from text RAM and the glyph row from font ROM, and selects the pixel bit.
- Drives serial_output and a delay-matched display_area, which the RGB stage consumes.
- Adds inverse video (character bit 7) and a blinking underline cursor.

Parameters:
COLS, 80, character columns per screen
ROWS, 30, character rows per screen
CHAR_W, 8, glyph width in pixels (fixed at 8; font row is one byte)
CHAR_H, 16, glyph height in pixels (fixed at 16)
ADDR_W, 12, text RAM address width (must satisfy COLS*ROWS <= 2^ADDR_W)
BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
vga_clk  in  1  pixel clock, rising edge
reset  in  1  asynchronous, active-low reset
x  in  10  current pixel column from sync generator
y  in  10  current pixel row from sync generator
display_area_in  in  1  high while x,y are inside the visible area
frame_start  in  1  one-cycle pulse once per frame
text_addr  out  ADDR_W  text RAM read address (registered)
text_data  in  8  text RAM data; valid the cycle after text_addr
font_addr  out  11  font ROM address {char[6:0], glyph_row[3:0]} (registered)
font_data  in  8  font ROM row; valid the cycle after font_addr; bit 7 = leftmost pixel
cursor_col  in  7  cursor character column
cursor_row  in  5  cursor character row
cursor_en  in  1  cursor enable
serial_output  out  1  pixel on/off to RGB stage
display_area  out  1  display_area_in delayed to align with serial_output

Behaviour:
- Reset (reset=0, async): clear all of the following.
  - Outputs: text_addr, font_addr, serial_output, display_area.
  - Internal state: all pipeline registers and the blink counter.
  - blink_phase is set to 1 (cursor visible). Takes effect immediately and independent of vga_clk.
- Cell decode: col = x>>3, glyph_col = x[2:0], row = y>>4, glyph_row = y[3:0].
- Pipeline: x,y,display_area_in sampled in cycle T.
  - T+1: text_addr = row*COLS + col when display_area_in=1, else 0. glyph_row, glyph_col, display_area, col and row are carried along the pipeline.
  - T+2: text_data valid from RAM.
  - T+3: font_addr = {text_data[6:0], glyph_row}. inv = text_data[7] is registered alongside.
  - T+4: font_data valid from ROM.
  - T+5: serial_output and display_area are registered and valid.
  - Latency is fixed at 5 cycles, fully pipelined with one pixel per clock and no stalls.
- Pixel: pix = font_data[7 - glyph_col] XOR inv.
- Cursor hit: cursor_en=1, blink_phase=1, cell (col,row) == (cursor_col,cursor_row), and glyph_row >= CHAR_H-2. On a hit pix is forced to 1, after the inversion is applied.
- serial_output = pix AND delayed display_area. It must be 0 whenever display_area is 0.
- Blink counter: increments on each frame_start.
  - When the counter is at BLINK_FRAMES-1 and frame_start occurs, it wraps to 0 and blink_phase toggles.
  - frame_start is ignored during reset.
- Boundaries:
  - Last cell (x=639, y=479) gives text_addr 2399.
  - x/y outside the visible area are masked via display_area_in and never produce an out-of-range address.
  - A reset mid-line flushes the pipeline. The first valid pixel appears 5 cycles after the first display_area_in=1 following reset release.
  - Cursor coordinates outside COLS/ROWS never hit.

Test Plan:
1. Reset: assert reset=0 mid-frame with active stimulus → text_addr=0, font_addr=0, serial_output=0, display_area=0 immediately; cursor visible on the first frame after release.
2. Latency/pixel order:
   - Stimulus: RAM[0]=0x41, ROM[{0x41,0}]=0x18; drive y=0, x=0..7 with display_area_in=1 from cycle 0.
   - Required: font_addr=0x410 at cycle 3; serial_output=0,0,0,1,1,0,0,0 on cycles 5..12; display_area=1 on cycles 5..12.
3. Addressing: x=639, y=479 → text_addr=2399 one cycle later. RAM[2399]=0x7F → font_addr={0x7F,15}=0x7FF.
4. Inverse video: RAM[0]=0xC1, same ROM row 0x18 → serial_output=1,1,1,0,0,1,1,1.
5. Cursor blink:
   - Stimulus: cursor_en=1, cursor=(3,2), all-zero font.
   - Required: pixels x=24..31, y=46..47 read 1 for frames 0–29; 0 for frames 30–59 (phase toggles on the 30th frame_start); 1 again from frame 60.
   - Other rows of the cell read 0 throughout.
6. Blanking: display_area_in=0 with nonzero font data → text_addr=0 one cycle later; serial_output=0 and display_area=0 five cycles later.
